// File: rtl/mole_hit_detector_if.sv
// Button/mole inputs and scoring outputs of the whack-a-mole hit detector.
// The detector uses the slave side; the board/mole generator uses master.
interface mole_hit_detector_if #(
    parameter int NUM_HOLES = 4
);
    logic                 game_active;
    logic [NUM_HOLES-1:0] buttons;
    logic [NUM_HOLES-1:0] mole_mask;
    logic                 player_scored;
    logic [2:0]           hit_index;
    logic                 miss;
    logic [NUM_HOLES-1:0] mole_clear;

    modport master (
        output game_active,
        output buttons,
        output mole_mask,
        input  player_scored,
        input  hit_index,
        input  miss,
        input  mole_clear
    );

    modport slave (
        input  game_active,
        input  buttons,
        input  mole_mask,
        output player_scored,
        output hit_index,
        output miss,
        output mole_clear
    );
endinterface

// File: rtl/mole_hit_detector.sv
// Whack-a-mole hit detector: synchronise, debounce and edge-detect each button,
// classify presses against the mole pattern and emit one scoring pulse per cycle.
module mole_hit_detector #(
    parameter int NUM_HOLES       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_CNT_W        = 20
) (
    input  logic               clkIn,
    input  logic               reset,
    mole_hit_detector_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [NUM_HOLES-1:0] ZERO_H  = {NUM_HOLES{1'b0}};
    localparam logic [DB_CNT_W-1:0]  ZERO_C  = {DB_CNT_W{1'b0}};
    localparam logic [DB_CNT_W-1:0]  ONE_C   = DB_CNT_W'(1);
    localparam logic [DB_CNT_W-1:0]  DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_HOLES-1:0] sync1_r;
    logic [NUM_HOLES-1:0] sync2_r;
    logic [NUM_HOLES-1:0] db_r;
    logic [NUM_HOLES-1:0] db_q_r;
    logic [DB_CNT_W-1:0]  cnt_r [NUM_HOLES];

    state_t               state_r;
    logic [NUM_HOLES-1:0] pending_r;
    logic [NUM_HOLES-1:0] lock_r;
    logic                 scored_r;
    logic [2:0]           hit_index_r;
    logic                 miss_r;
    logic [NUM_HOLES-1:0] mole_clear_r;

    logic [NUM_HOLES-1:0] press_s;
    logic [NUM_HOLES-1:0] hit_s;
    logic [NUM_HOLES-1:0] miss_vec_s;
    logic [NUM_HOLES-1:0] lock_nxt_s;
    logic [NUM_HOLES-1:0] pending_nxt_s;
    logic                 pick_vld_s;
    logic [2:0]           pick_idx_s;
    logic [NUM_HOLES-1:0] pick_oh_s;

    // Two-flop synchroniser, per-hole debounce counter and edge-detect history
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            sync1_r <= ZERO_H;
            sync2_r <= ZERO_H;
            db_r    <= ZERO_H;
            db_q_r  <= ZERO_H;
            for (int i = 0; i < NUM_HOLES; i++) begin
                cnt_r[i] <= ZERO_C;
            end
        end else begin
            sync1_r <= bus.buttons;
            sync2_r <= sync1_r;
            db_q_r  <= db_r;
            for (int i = 0; i < NUM_HOLES; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    cnt_r[i] <= ZERO_C;
                end else if (cnt_r[i] == DB_LAST) begin
                    db_r[i]  <= sync2_r[i];
                    cnt_r[i] <= ZERO_C;
                end else begin
                    cnt_r[i] <= cnt_r[i] + ONE_C;
                end
            end
        end
    end

    // Press classification, lock update and lowest-index pending selection
    always_comb begin
        press_s    = db_r & ~db_q_r;
        hit_s      = press_s & bus.mole_mask & ~lock_r;
        miss_vec_s = press_s & ~hit_s;
        // A lock survives only while its mole stays up
        lock_nxt_s = (lock_r | hit_s) & bus.mole_mask;
        pick_vld_s = 1'b0;
        pick_idx_s = 3'd0;
        pick_oh_s  = ZERO_H;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (pending_r[i] && !pick_vld_s) begin
                pick_vld_s   = 1'b1;
                pick_idx_s   = 3'(i);
                pick_oh_s[i] = 1'b1;
            end else begin
                pick_oh_s[i] = 1'b0;
            end
        end
        pending_nxt_s = (pending_r & ~pick_oh_s) | hit_s;
    end

    // Game-state FSM owning the hit queue, mole locks and registered outputs
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            pending_r    <= ZERO_H;
            lock_r       <= ZERO_H;
            scored_r     <= 1'b0;
            hit_index_r  <= 3'd0;
            miss_r       <= 1'b0;
            mole_clear_r <= ZERO_H;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pending_r    <= ZERO_H;
                    lock_r       <= ZERO_H;
                    scored_r     <= 1'b0;
                    hit_index_r  <= 3'd0;
                    miss_r       <= 1'b0;
                    mole_clear_r <= ZERO_H;
                    if (bus.game_active) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (!bus.game_active) begin
                        // Round over: drop anything still queued
                        state_r      <= ST_IDLE;
                        pending_r    <= ZERO_H;
                        lock_r       <= ZERO_H;
                        scored_r     <= 1'b0;
                        hit_index_r  <= 3'd0;
                        miss_r       <= 1'b0;
                        mole_clear_r <= ZERO_H;
                    end else begin
                        state_r      <= ST_ARMED;
                        pending_r    <= pending_nxt_s;
                        lock_r       <= lock_nxt_s;
                        scored_r     <= pick_vld_s;
                        hit_index_r  <= pick_idx_s;
                        miss_r       <= |miss_vec_s;
                        mole_clear_r <= pick_oh_s;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    pending_r    <= ZERO_H;
                    lock_r       <= ZERO_H;
                    scored_r     <= 1'b0;
                    hit_index_r  <= 3'd0;
                    miss_r       <= 1'b0;
                    mole_clear_r <= ZERO_H;
                end
            endcase
        end
    end

    assign bus.player_scored = scored_r;
    assign bus.hit_index     = hit_index_r;
    assign bus.miss          = miss_r;
    assign bus.mole_clear    = mole_clear_r;
endmodule
